segment_mean_unit: RTL and testbench

Streaming per-segment mean calculator placed directly upstream of, and wrapping, the 8-bit reciprocal LUT.
- Accumulates 8-bit pixel values over a segment delimited by `s_last`.
- Converts the beat count to a LUT index and multiplies the accumulated sum by the returned 8-bit fractional reciprocal.
- Emits an approximate mean plus the raw sum and count on a valid/ready output.
- Used by the centroid/cluster path to avoid a true divider.

---
 rtl/seg_mean_pkg.sv | 24 ++
 rtl/udivision_LUT_8bit_int_to_8bit_frac.sv | 28 ++
 rtl/segment_mean_unit.sv | 125 ++++++++++++
 tb/tb_segment_mean_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_mean_pkg.sv
// Shared widths, state encoding and result payload for the segment mean unit.
package seg_mean_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SUM_W  = 16;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned MAX_N  = 256;
  localparam int unsigned PROD_W = SUM_W + DATA_W;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DIV   = 2'd1,
    HOLD  = 2'd2
  } seg_state_t;

  // Result payload presented on the m_* side.
  typedef struct packed {
    logic [DATA_W-1:0] mean;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  count;
    logic              ovf;
  } seg_result_t;

endpackage

// File: rtl/udivision_LUT_8bit_int_to_8bit_frac.sv
// Reciprocal LUT: index n -> 8-bit fraction approximating 1/(n+1).
// Ports:
//   index_i  8-bit index (beat count minus one)
//   recip_o  floor(256/(n+1)); 255 for n = 0, 1 for n >= 128
module udivision_LUT_8bit_int_to_8bit_frac
  import seg_mean_pkg::*;
(
  input  logic [DATA_W-1:0] index_i,
  output logic [DATA_W-1:0] recip_o
);

  logic [DATA_W:0] divisor_c;

  assign divisor_c = (DATA_W+1)'(index_i) + (DATA_W+1)'(1);

  // 256/1 does not fit in 8 bits, so index 0 saturates to 255.
  always_comb begin
    recip_o = '0;
    if (index_i == '0) begin
      recip_o = 8'd255;
    end else if (index_i >= 8'd128) begin
      recip_o = 8'd1;
    end else begin
      recip_o = DATA_W'((DATA_W+1)'(256) / divisor_c);
    end
  end

endmodule

// File: rtl/segment_mean_unit.sv
// Streaming per-segment mean: accumulates 8-bit beats until s_last, then
// multiplies the sum by a LUT reciprocal of the count to approximate the mean.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last  input beat stream
//   m_valid/m_ready                result handshake
//   m_mean, m_sum, m_count, m_ovf  approximate mean, exact sum, beats, overflow
module segment_mean_unit
  import seg_mean_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_mean,
  output logic [SUM_W-1:0]  m_sum,
  output logic [CNT_W-1:0]  m_count,
  output logic              m_ovf
);

  seg_state_t        state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  seg_result_t       res_q, res_d;

  logic [DATA_W-1:0] lut_idx_c;
  logic [DATA_W-1:0] recip_c;
  logic [PROD_W-1:0] product_c;

  assign lut_idx_c = DATA_W'(cnt_q - CNT_W'(1));
  assign product_c = PROD_W'(sum_q) * PROD_W'(recip_c);

  udivision_LUT_8bit_int_to_8bit_frac u_lut (
    .index_i (lut_idx_c),
    .recip_o (recip_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    m_valid_d = 1'b0;
    s_ready_d = 1'b0;

    unique case (state_q)
      ACCUM: begin
        if (s_valid && s_ready_q) begin
          if (cnt_q < CNT_W'(MAX_N)) begin
            sum_d = sum_q + SUM_W'(s_data);
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (s_last) begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        // A single beat bypasses the LUT, whose index-0 entry is saturated.
        res_d.mean  = (cnt_q == CNT_W'(1)) ? sum_q[DATA_W-1:0]
                                           : DATA_W'(product_c >> DATA_W);
        res_d.sum   = sum_q;
        res_d.count = cnt_q;
        res_d.ovf   = ovf_q;
        state_d     = HOLD;
      end
      HOLD: begin
        // m_valid rises one cycle after HOLD entry, two after the last beat.
        m_valid_d = 1'b1;
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          sum_d     = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          state_d   = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase

    s_ready_d = (state_d == ACCUM);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      sum_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      res_q     <= res_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_mean  = res_q.mean;
  assign m_sum   = res_q.sum;
  assign m_count = res_q.count;
  assign m_ovf   = res_q.ovf;

endmodule

// File: tb/tb_segment_mean_unit.sv
// Directed bench for segment_mean_unit with a cycle-level behavioural model.
module tb_segment_mean_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_mean;
  logic [15:0] m_sum;
  logic [8:0]  m_count;
  logic        m_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  segment_mean_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_mean  (m_mean),
    .m_sum   (m_sum),
    .m_count (m_count),
    .m_ovf   (m_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int recip_of(input int idx);
    if (idx == 0) return 255;
    if (idx >= 128) return 1;
    return 256 / (idx + 1);
  endfunction

  function automatic int mean_of(input int sum, input int n);
    if (n == 1) return sum % 256;
    return ((sum * recip_of(n - 1)) / 256) % 256;
  endfunction

  int cyc = 0;
  int md_n = 0, md_sum = 0;
  bit md_ovf = 0;
  bit md_rdy = 0;
  bit md_pend = 0;
  int md_vfrom = 0;
  int ex_mean = 0, ex_sum = 0, ex_cnt = 0;
  bit ex_ovf = 0;
  bit vis_valid;
  bit chk_en = 0;

  always @(posedge clk) begin
    vis_valid = md_pend && (cyc >= md_vfrom);
    cyc++;
    if (!rst_n) begin
      md_n = 0; md_sum = 0; md_ovf = 0; md_rdy = 0; md_pend = 0;
    end else if (md_pend) begin
      if (vis_valid && m_ready) begin
        md_pend = 0; md_rdy = 1; md_n = 0; md_sum = 0; md_ovf = 0;
      end
    end else begin
      if (s_valid && md_rdy) begin
        if (md_n < 256) begin
          md_sum += int'(s_data);
          md_n++;
        end else begin
          md_ovf = 1;
        end
        if (s_last) begin
          ex_sum = md_sum; ex_cnt = md_n; ex_ovf = md_ovf;
          ex_mean = mean_of(md_sum, md_n);
          md_pend = 1;
          md_vfrom = cyc + 2;
        end
      end
      md_rdy = !md_pend;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("s_ready", 32'(s_ready), 32'(md_rdy));
      check("m_valid", 32'(m_valid), 32'(md_pend && (cyc >= md_vfrom)));
      if (md_pend && (cyc >= md_vfrom)) begin
        check("m_mean",  32'(m_mean),  32'(ex_mean));
        check("m_sum",   32'(m_sum),   32'(ex_sum));
        check("m_count", 32'(m_count), 32'(ex_cnt));
        check("m_ovf",   32'(m_ovf),   32'(ex_ovf));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_beat(input logic [7:0] d, input logic last);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int i = 0; i < 20 && !s_ready; i++) @(negedge clk);
    check("beat_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic send_rep(input int n, input logic [7:0] d);
    for (int i = 1; i <= n; i++) send_beat(d, logic'(i == n));
  endtask

  task automatic wait_result(input string name, input int e_mean, input int e_sum,
                             input int e_cnt, input int e_ovf);
    int lat;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      if (m_valid) begin
        lat = i - 1;
        break;
      end
    end
    check({name, "_latency"}, 32'(lat),     32'd2);
    check({name, "_mean"},    32'(m_mean),  32'(e_mean));
    check({name, "_sum"},     32'(m_sum),   32'(e_sum));
    check({name, "_count"},   32'(m_count), 32'(e_cnt));
    check({name, "_ovf"},     32'(m_ovf),   32'(e_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_mean",  32'(m_mean),  32'd0);
    check("rst_m_sum",   32'(m_sum),   32'd0);
    check("rst_m_count", 32'(m_count), 32'd0);
    check("rst_m_ovf",   32'(m_ovf),   32'd0);
    rst_n = 1'b1;

    send_beat(8'd10, 1'b0); send_beat(8'd20, 1'b0); send_beat(8'd30, 1'b1);
    wait_result("three", 19, 60, 3, 0);

    send_beat(8'd200, 1'b1);
    wait_result("single", 200, 200, 1, 0);

    send_rep(4, 8'd255);
    wait_result("four255", 255, 1020, 4, 0);

    send_rep(3, 8'd0);
    wait_result("zeros", 0, 0, 3, 0);

    send_rep(128, 8'd200);
    wait_result("n128", 200, 25600, 128, 0);

    send_rep(256, 8'd255);
    wait_result("n256", 255, 65280, 256, 0);

    send_rep(300, 8'd1);
    wait_result("ovf300", 1, 256, 256, 1);

    // Backpressure: result must hold while m_ready is low.
    @(negedge clk);
    m_ready = 1'b0;
    send_beat(8'd5, 1'b0); send_beat(8'd7, 1'b1);
    wait_result("hold", 6, 12, 2, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 8'd99; s_last = 1'b1;
      check("hold_m_valid", 32'(m_valid), 32'd1);
      check("hold_s_ready", 32'(s_ready), 32'd0);
      check("hold_m_mean",  32'(m_mean),  32'd6);
      check("hold_m_sum",   32'(m_sum),   32'd12);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    check("release_m_valid", 32'(m_valid), 32'd0);
    check("release_s_ready", 32'(s_ready), 32'd1);

    // Reset in the middle of a segment drops it.
    send_beat(8'd50, 1'b0); send_beat(8'd50, 1'b0);
    @(negedge clk);
    s_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    rst_n = 1'b1;
    send_beat(8'd8, 1'b0); send_beat(8'd8, 1'b1);
    wait_result("after_rst", 8, 16, 2, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
